// File: rtl/demod_frame_sched.sv
// Frame-level controller for the DCSK demodulator: configuration latch, flush, chip gating,
// word counting with timeout, and a 2-entry {word,last} output buffer.
module demod_frame_sched #(
    parameter int unsigned WCNT_W      = 16,
    parameter int unsigned FLUSH_CYC   = 4,
    parameter int unsigned TIMEOUT_CYC = 65535
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Start,
    input  logic              Abort,
    input  logic [1:0]        Cfg_Sf_Sel,
    input  logic [WCNT_W-1:0] Cfg_Num_Words,
    input  logic              Chip_In,
    input  logic              Chip_Valid,
    output logic              Dem_In_Mod_Data,
    output logic              Dem_Valid,
    output logic [1:0]        Dem_Spread_Factor_Sel,
    output logic              Dem_N_Rst,
    input  logic [31:0]       Dem_Out_Data,
    input  logic              Dem_Valid_Data,
    output logic [31:0]       Out_Word,
    output logic              Out_Valid,
    input  logic              Out_Ready,
    output logic              Out_Last,
    output logic              Busy,
    output logic              Done,
    output logic              Err_Overflow,
    output logic              Err_Timeout
);

    localparam int unsigned TO_W = $clog2(TIMEOUT_CYC + 1);
    localparam int unsigned FL_W = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
    localparam logic [TO_W-1:0] TO_LIM  = TO_W'(TIMEOUT_CYC);
    localparam logic [FL_W-1:0] FL_LAST = FL_W'(FLUSH_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FLUSH,
        S_RUN,
        S_DRAIN
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        sf_q, sf_d;
    logic [WCNT_W-1:0] target_q, target_d;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;
    logic [WCNT_W-1:0] wcnt_inc;
    logic [TO_W-1:0]   tcnt_q, tcnt_d;
    logic [TO_W-1:0]   tcnt_inc;
    logic [FL_W-1:0]   fcnt_q, fcnt_d;
    logic              nrst_q, nrst_d;
    logic              done_q, done_d;
    logic              err_ovf_q, err_ovf_d;
    logic              err_to_q, err_to_d;

    logic [31:0]       mem_word_q [2];
    logic              mem_last_q [2];
    logic              rd_ptr_q, rd_ptr_d;
    logic              wr_ptr_q, wr_ptr_d;
    logic [1:0]        cnt_q, cnt_d;

    logic              pop;
    logic              push_req;
    logic              push_last;
    logic              push_ok;
    logic              flush_fifo;

    assign wcnt_inc = wcnt_q + WCNT_W'(1);
    assign tcnt_inc = tcnt_q + TO_W'(1);
    assign pop      = (cnt_q != 2'd0) && Out_Ready;

    always_comb begin
        state_d    = state_q;
        sf_d       = sf_q;
        target_d   = target_q;
        wcnt_d     = wcnt_q;
        tcnt_d     = tcnt_q;
        fcnt_d     = fcnt_q;
        done_d     = 1'b0;
        err_ovf_d  = err_ovf_q;
        err_to_d   = err_to_q;
        push_req   = 1'b0;
        push_last  = 1'b0;
        flush_fifo = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (Start && !Abort && (Cfg_Num_Words != '0)) begin
                    state_d   = S_FLUSH;
                    sf_d      = Cfg_Sf_Sel;
                    target_d  = Cfg_Num_Words;
                    wcnt_d    = '0;
                    fcnt_d    = '0;
                    err_ovf_d = 1'b0;
                    err_to_d  = 1'b0;
                end
            end
            S_FLUSH: begin
                if (fcnt_q == FL_LAST) begin
                    state_d = S_RUN;
                    tcnt_d  = '0;
                end else begin
                    fcnt_d = fcnt_q + FL_W'(1);
                end
            end
            S_RUN: begin
                if (Dem_Valid_Data) begin
                    push_req  = 1'b1;
                    push_last = (wcnt_inc == target_q);
                    tcnt_d    = '0;
                    if (wcnt_q != target_q)
                        wcnt_d = wcnt_inc;
                    if (push_last)
                        state_d = S_DRAIN;
                end else begin
                    tcnt_d = tcnt_inc;
                    if (tcnt_inc == TO_LIM) begin
                        err_to_d = 1'b1;
                        state_d  = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (cnt_q == 2'd0) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Abort overrides everything above, including a push in the same cycle.
        if (Abort && (state_q != S_IDLE)) begin
            state_d    = S_IDLE;
            done_d     = 1'b0;
            push_req   = 1'b0;
            flush_fifo = 1'b1;
        end

        push_ok = push_req && ((cnt_q != 2'd2) || pop);
        if (push_req && !push_ok)
            err_ovf_d = 1'b1;

        rd_ptr_d = rd_ptr_q ^ pop;
        wr_ptr_d = wr_ptr_q ^ push_ok;
        case ({push_ok, pop})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase
        if (flush_fifo) begin
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
            cnt_d    = 2'd0;
        end

        nrst_d = (state_d != S_FLUSH);
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q   <= S_IDLE;
            sf_q      <= '0;
            target_q  <= '0;
            wcnt_q    <= '0;
            tcnt_q    <= '0;
            fcnt_q    <= '0;
            nrst_q    <= 1'b0;
            done_q    <= 1'b0;
            err_ovf_q <= 1'b0;
            err_to_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            wr_ptr_q  <= 1'b0;
            cnt_q     <= 2'd0;
        end else begin
            state_q   <= state_d;
            sf_q      <= sf_d;
            target_q  <= target_d;
            wcnt_q    <= wcnt_d;
            tcnt_q    <= tcnt_d;
            fcnt_q    <= fcnt_d;
            nrst_q    <= nrst_d;
            done_q    <= done_d;
            err_ovf_q <= err_ovf_d;
            err_to_q  <= err_to_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            cnt_q     <= cnt_d;
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            for (int unsigned i = 0; i < 2; i++) begin
                mem_word_q[i] <= '0;
                mem_last_q[i] <= 1'b0;
            end
        end else if (push_ok) begin
            mem_word_q[wr_ptr_q] <= Dem_Out_Data;
            mem_last_q[wr_ptr_q] <= push_last;
        end
    end

    assign Dem_Valid             = (state_q == S_RUN) && Chip_Valid;
    assign Dem_In_Mod_Data       = (state_q == S_RUN) && Chip_In;
    assign Dem_Spread_Factor_Sel = sf_q;
    assign Dem_N_Rst             = nrst_q;
    assign Out_Valid             = (cnt_q != 2'd0);
    assign Out_Word              = mem_word_q[rd_ptr_q];
    assign Out_Last              = Out_Valid && mem_last_q[rd_ptr_q];
    assign Busy                  = (state_q != S_IDLE);
    assign Done                  = done_q;
    assign Err_Overflow          = err_ovf_q;
    assign Err_Timeout           = err_to_q;

endmodule

// File: tb/tb_demod_frame_sched.sv
// Directed bench for demod_frame_sched: nominal frame, overflow, full push/pop, timeout,
// abort / ignored starts, and reset mid-frame.
module tb_demod_frame_sched;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        Start, Abort;
    logic [1:0]  Cfg_Sf_Sel;
    logic [15:0] Cfg_Num_Words;
    logic        Chip_In, Chip_Valid;
    logic        Dem_In_Mod_Data, Dem_Valid, Dem_N_Rst;
    logic [1:0]  Dem_Spread_Factor_Sel;
    logic [31:0] Dem_Out_Data;
    logic        Dem_Valid_Data;
    logic [31:0] Out_Word;
    logic        Out_Valid, Out_Ready, Out_Last;
    logic        Busy, Done, Err_Overflow, Err_Timeout;

    int n_cmp = 0;
    int n_err = 0;

    always #5 Clk = ~Clk;

    demod_frame_sched #(
        .WCNT_W(16),
        .FLUSH_CYC(4),
        .TIMEOUT_CYC(16)
    ) dut (
        .Clk(Clk), .Rst(Rst), .Start(Start), .Abort(Abort),
        .Cfg_Sf_Sel(Cfg_Sf_Sel), .Cfg_Num_Words(Cfg_Num_Words),
        .Chip_In(Chip_In), .Chip_Valid(Chip_Valid),
        .Dem_In_Mod_Data(Dem_In_Mod_Data), .Dem_Valid(Dem_Valid),
        .Dem_Spread_Factor_Sel(Dem_Spread_Factor_Sel), .Dem_N_Rst(Dem_N_Rst),
        .Dem_Out_Data(Dem_Out_Data), .Dem_Valid_Data(Dem_Valid_Data),
        .Out_Word(Out_Word), .Out_Valid(Out_Valid), .Out_Ready(Out_Ready),
        .Out_Last(Out_Last), .Busy(Busy), .Done(Done),
        .Err_Overflow(Err_Overflow), .Err_Timeout(Err_Timeout)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic strobe(input logic [31:0] w);
        Dem_Out_Data   = w;
        Dem_Valid_Data = 1'b1;
        tick();
        Dem_Valid_Data = 1'b0;
    endtask

    task automatic start_frame(input logic [1:0] sf, input logic [15:0] nw);
        Cfg_Sf_Sel    = sf;
        Cfg_Num_Words = nw;
        Start         = 1'b1;
        tick();
        Start = 1'b0;
    endtask

    task automatic wait_run();
        int n = 0;
        while (!(Busy && Dem_N_Rst) && n < 20) begin
            tick();
            n++;
        end
        chk("reach_run", {31'd0, Busy && Dem_N_Rst}, 32'd1);
    endtask

    initial begin
        int lowcnt;
        Rst = 1'b1; Start = 0; Abort = 0; Cfg_Sf_Sel = 0; Cfg_Num_Words = 0;
        Chip_In = 1; Chip_Valid = 1; Dem_Out_Data = 0; Dem_Valid_Data = 0; Out_Ready = 0;
        repeat (3) @(posedge Clk);
        #1;
        chk("rst_nrst",  {31'd0, Dem_N_Rst}, 32'd0);
        chk("rst_busy",  {31'd0, Busy}, 32'd0);
        chk("rst_oval",  {31'd0, Out_Valid}, 32'd0);
        chk("rst_word",  Out_Word, 32'd0);
        chk("rst_dval",  {31'd0, Dem_Valid}, 32'd0);
        chk("rst_sf",    {30'd0, Dem_Spread_Factor_Sel}, 32'd0);
        chk("rst_err",   {30'd0, Err_Overflow, Err_Timeout}, 32'd0);
        Rst = 1'b0; Chip_Valid = 0; Chip_In = 0;
        tick();
        chk("idle_nrst", {31'd0, Dem_N_Rst}, 32'd1);

        // Nominal frame
        Out_Ready = 1'b1;
        start_frame(2'd2, 16'd3);
        chk("nom_sf", {30'd0, Dem_Spread_Factor_Sel}, 32'd2);
        lowcnt = 0;
        while (!Dem_N_Rst && lowcnt < 20) begin
            lowcnt++;
            tick();
        end
        chk("nom_flush_len", lowcnt, 32'd4);
        Chip_Valid = 1; Chip_In = 1;
        #1;
        chk("nom_dval", {30'd0, Dem_Valid, Dem_In_Mod_Data}, 32'd3);
        Chip_Valid = 0; Chip_In = 0;
        strobe(32'h1111_0001);
        chk("nom_w1", Out_Word, 32'h1111_0001);
        chk("nom_l1", {31'd0, Out_Last}, 32'd0);
        strobe(32'h1111_0002);
        chk("nom_w2", Out_Word, 32'h1111_0002);
        chk("nom_l2", {31'd0, Out_Last}, 32'd0);
        strobe(32'h1111_0003);
        chk("nom_w3", Out_Word, 32'h1111_0003);
        chk("nom_l3", {31'd0, Out_Last}, 32'd1);
        tick();
        chk("nom_drain", {29'd0, Out_Valid, Done, Busy}, 32'b001);
        tick();
        chk("nom_done", {30'd0, Done, Busy}, 32'b10);
        chk("nom_err", {30'd0, Err_Overflow, Err_Timeout}, 32'd0);
        tick();
        chk("nom_done_once", {31'd0, Done}, 32'd0);

        // Backpressure / overflow
        Out_Ready = 1'b0;
        start_frame(2'd1, 16'd3);
        wait_run();
        strobe(32'hA000_0001);
        strobe(32'hA000_0002);
        strobe(32'hA000_0003);
        chk("ovf_head", Out_Word, 32'hA000_0001);
        chk("ovf_flag", {31'd0, Err_Overflow}, 32'd1);
        chk("ovf_last", {31'd0, Out_Last}, 32'd0);
        tick();
        chk("ovf_hold", Out_Word, 32'hA000_0001);
        Out_Ready = 1'b1;
        tick();
        chk("ovf_w2", Out_Word, 32'hA000_0002);
        chk("ovf_l2", {30'd0, Out_Valid, Out_Last}, 32'b10);
        tick();
        chk("ovf_empty", {30'd0, Out_Valid, Done}, 32'd0);
        tick();
        chk("ovf_done", {30'd0, Done, Busy}, 32'b10);

        // Full FIFO with simultaneous push and pop
        Out_Ready = 1'b0;
        start_frame(2'd0, 16'd3);
        chk("full_errclr", {31'd0, Err_Overflow}, 32'd0);
        wait_run();
        strobe(32'hB000_0001);
        strobe(32'hB000_0002);
        Out_Ready = 1'b1;
        strobe(32'hB000_0003);
        chk("full_noovf", {31'd0, Err_Overflow}, 32'd0);
        chk("full_w2", Out_Word, 32'hB000_0002);
        tick();
        chk("full_w3", Out_Word, 32'hB000_0003);
        chk("full_l3", {31'd0, Out_Last}, 32'd1);
        tick();
        tick();
        chk("full_done", {31'd0, Done}, 32'd1);

        // Timeout
        Out_Ready = 1'b0;
        start_frame(2'd0, 16'd5);
        wait_run();
        strobe(32'hC000_0001);
        repeat (15) tick();
        chk("to_pre", {30'd0, Err_Timeout, Busy}, 32'b01);
        tick();
        chk("to_set", {31'd0, Err_Timeout}, 32'd1);
        chk("to_word", Out_Word, 32'hC000_0001);
        chk("to_last", {30'd0, Out_Valid, Out_Last}, 32'b10);
        Out_Ready = 1'b1;
        tick();
        tick();
        chk("to_done", {31'd0, Done}, 32'd1);
        Out_Ready = 1'b0;
        start_frame(2'd1, 16'd2);
        chk("to_clr", {31'd0, Err_Timeout}, 32'd0);

        // Abort and ignored starts
        wait_run();
        start_frame(2'd3, 16'd7);
        chk("busy_start_sf", {30'd0, Dem_Spread_Factor_Sel}, 32'd1);
        strobe(32'hD000_0001);
        chk("ab_oval", {31'd0, Out_Valid}, 32'd1);
        Abort = 1'b1; Start = 1'b1;
        tick();
        Abort = 1'b0; Start = 1'b0;
        chk("ab_state", {29'd0, Busy, Out_Valid, Done}, 32'd0);
        tick();
        chk("ab_nodone", {31'd0, Done}, 32'd0);
        start_frame(2'd2, 16'd0);
        chk("zero_start", {31'd0, Busy}, 32'd0);
        Abort = 1'b1;
        start_frame(2'd2, 16'd3);
        Abort = 1'b0;
        chk("ab_start_same", {31'd0, Busy}, 32'd0);

        // Reset mid-frame
        start_frame(2'd3, 16'd3);
        wait_run();
        strobe(32'hE000_0001);
        chk("mr_oval", {31'd0, Out_Valid}, 32'd1);
        Rst = 1'b1; Chip_Valid = 1'b1;
        #1;
        chk("mr_nrst", {31'd0, Dem_N_Rst}, 32'd0);
        chk("mr_outs", {28'd0, Busy, Out_Valid, Dem_Valid, Out_Last}, 32'd0);
        chk("mr_sf", {30'd0, Dem_Spread_Factor_Sel}, 32'd0);
        chk("mr_word", Out_Word, 32'd0);
        tick();
        Rst = 1'b0; Chip_Valid = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
